sim_run_ctrl: RTL and testbench
===============================

# sim_run_ctrl

Synthesizable run controller for the CPU test harness, placed beside `top`. It drives the DUT reset with a programmable pulse and watches the DUT memory-write bus for a pass/fail signature. It enforces a cycle timeout and can repeat the run several times, re-resetting the DUT between runs. It replaces fixed-delay bench sequencing with a parametrised, checkable sequencer usable both in simulation and on an FPGA.

## Interface
- `RST_CYCLES`, 2: cycles `dut_reset` is held high per run (≥1)
- `TIMEOUT_CYCLES`, 50: run-phase cycles before timeout (≥1)
- `NUM_RUNS`, 2: consecutive runs per `start` (≥1)
- `ADDR_W`, 32: memory address width
- `DATA_W`, 32: memory data width
- `PASS_ADDR`, 32'd100: signature address
- `PASS_DATA`, 32'd7: value meaning pass; any other value written to `PASS_ADDR` means fail
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `start` in 1: begin a sequence; sampled in IDLE/DONE only
- `mem_we` in 1: DUT write enable
- `mem_addr` in ADDR_W: DUT address_to_mem
- `mem_wdata` in DATA_W: DUT data_to_mem
- `dut_reset` out 1: active-high reset to DUT
- `busy` out 1: high in RESET/RUN
- `done` out 1: high in DONE
- `result` out 2: 0 none, 1 pass, 2 fail (bad data), 3 timeout
- `run_idx` out $clog2(NUM_RUNS+1): index of current/last run
- `cycle_count` out $clog2(TIMEOUT_CYCLES+1): run-phase cycles elapsed
- `wr_count` out 16: DUT writes seen in current run, saturating
- `last_wr_addr` out ADDR_W, `last_wr_data` out DATA_W: see Configuration

## Operation
- States: IDLE, RESET, RUN, DONE.
- IDLE: `start`=1 → RESET, `run_idx`=0, `result`=0.
- RESET: `dut_reset`=1; counts RST_CYCLES cycles, then → RUN. Clears `cycle_count` and `wr_count` on entry. Bus inputs are ignored.
- RUN: `dut_reset`=0; `cycle_count` increments every cycle. A write with `mem_we`=1 increments `wr_count` (saturating at 16'hFFFF).
- Write with `mem_addr`==PASS_ADDR: `mem_wdata`==PASS_DATA → run pass; otherwise → fail (2).
- `cycle_count` reaching TIMEOUT_CYCLES with no signature → timeout (3).
- Run passes and `run_idx`<NUM_RUNS-1: `run_idx`++ and → RESET (re-reset of a running DUT). Otherwise latch `result` and → DONE.
- First failure or timeout aborts the remaining runs.
- DONE: outputs hold; `dut_reset`=1. `start`=1 restarts as from IDLE.
- `start` while busy is ignored.
- Signature write on the same cycle that the timeout count is reached: the write wins.

## Timing
- Reset values: `dut_reset`=1, `busy`=0, `done`=0, `result`=0, `run_idx`=0, `cycle_count`=0, `wr_count`=0, `last_wr_*`=0, state IDLE.
- `reset` low at any time returns to IDLE asynchronously, with `dut_reset` forced to 1 immediately.
- `start` high at edge N → `dut_reset`=1 from N+1 through N+RST_CYCLES, low from N+RST_CYCLES+1.
- Signature write sampled at edge M → `result` and DONE visible after M+1 (one-cycle latency). A next run's RESET likewise starts at M+1.
- Timeout: DONE after edge number TIMEOUT_CYCLES of RUN.
- All outputs are registered; no combinational paths from inputs to outputs.

## Configuration
- `SIM_RUN_CTRL_WRLOG_EN` defined: `last_wr_addr`/`last_wr_data` capture every RUN-phase write, are cleared on entry to RESET, and hold in DONE.
- Not defined: both ports are tied to 0 and no capture registers exist. All other behaviour is identical.

## Structure
- Package `sim_run_pkg`: state enum (IDLE, RESET, RUN, DONE) and result-code constants (RES_NONE, RES_PASS, RES_FAIL, RES_TIMEOUT).
- One sub-module, `run_timer`: a loadable, clear-able up-counter with terminal flag, instanced for the RESET length and the RUN timeout.

## Test plan
- Defaults, `start` pulse, DUT model writes 7 to address 100 at RUN cycle 10 in each run → `dut_reset` high 2 cycles twice, `run_idx` ends 1, `result`=1, `done`=1.
- Write 5 to address 100 in run 0 → `result`=2, DONE after one cycle, no second reset pulse, `run_idx`=0.
- No signature write → `result`=3 exactly at `cycle_count`=50; `wr_count` equals the number of DUT writes issued.
- Signature write on RUN cycle 50 → `result`=1, not 3.
- `reset` low during RUN at cycle 20 → immediately `dut_reset`=1, `busy`=0, all counters 0. A later `start` runs a full sequence cleanly.
- With `SIM_RUN_CTRL_WRLOG_EN`: writes (0x10,0xAA) then (100,7) → `last_wr_addr`=100, `last_wr_data`=7 in DONE. Without the macro, both read 0.

Source files
------------

// File: rtl/sim_run_pkg.sv
// Shared types for the CPU test-harness run controller: FSM state encoding and result codes.
package sim_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] RES_NONE    = 2'd0;
  localparam logic [1:0] RES_PASS    = 2'd1;
  localparam logic [1:0] RES_FAIL    = 2'd2;
  localparam logic [1:0] RES_TIMEOUT = 2'd3;

endpackage

// File: rtl/run_timer.sv
// Loadable, clearable up-counter; term_o flags that the next enabled count reaches TERM.
module run_timer #(
  parameter int W    = 8,
  parameter int TERM = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         term_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)       count_d = '0;
    else if (load_i) count_d = load_val_i;
    else if (en_i)   count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;
  assign term_o  = (count_q == W'(TERM - 1));

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: pulses DUT reset, watches the write bus for a pass/fail signature, enforces a timeout.
// Optional write logging of last RUN-phase write enabled by defining SIM_RUN_CTRL_WRLOG_EN.
module sim_run_ctrl
  import sim_run_pkg::*;
#(
  parameter int                RST_CYCLES     = 2,
  parameter int                TIMEOUT_CYCLES = 50,
  parameter int                NUM_RUNS       = 2,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] PASS_ADDR      = 32'd100,
  parameter logic [DATA_W-1:0] PASS_DATA      = 32'd7
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  mem_we,
  input  logic [ADDR_W-1:0]                     mem_addr,
  input  logic [DATA_W-1:0]                     mem_wdata,
  output logic                                  dut_reset,
  output logic                                  busy,
  output logic                                  done,
  output logic [1:0]                            result,
  output logic [$clog2(NUM_RUNS+1)-1:0]         run_idx,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]   cycle_count,
  output logic [15:0]                           wr_count,
  output logic [ADDR_W-1:0]                     last_wr_addr,
  output logic [DATA_W-1:0]                     last_wr_data
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int IDX_W = $clog2(NUM_RUNS + 1);

  state_e           state_q, state_d;
  logic [1:0]       result_q, result_d;
  logic [IDX_W-1:0] run_idx_q, run_idx_d;
  logic [15:0]      wr_count_q, wr_count_d;
  logic             enter_reset, in_run, sig_hit;
  logic             rst_term, run_term;
  logic [RST_W-1:0] rst_count;

  assign in_run  = (state_q == ST_RUN);
  assign sig_hit = in_run && mem_we && (mem_addr == PASS_ADDR);

  run_timer #(.W(RST_W), .TERM(RST_CYCLES)) u_rst_timer (
    .clk_i(clk), .rst_n_i(reset), .clr_i(enter_reset), .load_i(1'b0),
    .load_val_i('0), .en_i(state_q == ST_RESET), .count_o(rst_count), .term_o(rst_term)
  );

  run_timer #(.W(CNT_W), .TERM(TIMEOUT_CYCLES)) u_run_timer (
    .clk_i(clk), .rst_n_i(reset), .clr_i(enter_reset), .load_i(1'b0),
    .load_val_i('0), .en_i(in_run), .count_o(cycle_count), .term_o(run_term)
  );

  // A signature on the timeout edge takes priority over the timeout.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    run_idx_d   = run_idx_q;
    enter_reset = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RESET;
          result_d    = RES_NONE;
          run_idx_d   = '0;
          enter_reset = 1'b1;
        end
      end
      ST_RESET: begin
        if (rst_term) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (sig_hit) begin
          if (mem_wdata != PASS_DATA) begin
            result_d = RES_FAIL;
            state_d  = ST_DONE;
          end else if (run_idx_q < IDX_W'(NUM_RUNS - 1)) begin
            run_idx_d   = run_idx_q + 1'b1;
            state_d     = ST_RESET;
            enter_reset = 1'b1;
          end else begin
            result_d = RES_PASS;
            state_d  = ST_DONE;
          end
        end else if (run_term) begin
          result_d = RES_TIMEOUT;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (enter_reset)                                wr_count_d = '0;
    else if (in_run && mem_we && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      result_q   <= RES_NONE;
      run_idx_q  <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      run_idx_q  <= run_idx_d;
      wr_count_q <= wr_count_d;
    end
  end

`ifdef SIM_RUN_CTRL_WRLOG_EN
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [DATA_W-1:0] last_data_q, last_data_d;

  always_comb begin
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    if (enter_reset) begin
      last_addr_d = '0;
      last_data_d = '0;
    end else if (in_run && mem_we) begin
      last_addr_d = mem_addr;
      last_data_d = mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  assign last_wr_addr = last_addr_q;
  assign last_wr_data = last_data_q;
`else
  assign last_wr_addr = '0;
  assign last_wr_data = '0;
`endif

  assign dut_reset = (state_q != ST_RUN);
  assign busy      = (state_q == ST_RESET) || (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign run_idx   = run_idx_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Scoreboard bench for sim_run_ctrl with default parameters; a small DUT model drives the write bus.
module tb_sim_run_ctrl;

  localparam int RST = 2;
  localparam int TO  = 50;
  localparam int NR  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        dut_reset, busy, done;
  logic [1:0]  result;
  logic [1:0]  run_idx;
  logic [5:0]  cycle_count;
  logic [15:0] wr_count;
  logic [31:0] last_wr_addr, last_wr_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  res;
    logic [1:0]  ridx;
    int          cyc;
    logic [15:0] wrc;
    int          runs;
    logic [31:0] la;
    logic [31:0] ld;
  } exp_t;

  exp_t sb[$];

  sim_run_ctrl dut (
    .clk(clk), .reset(rst_n), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .dut_reset(dut_reset), .busy(busy), .done(done), .result(result),
    .run_idx(run_idx), .cycle_count(cycle_count), .wr_count(wr_count),
    .last_wr_addr(last_wr_addr), .last_wr_data(last_wr_data)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dut_reset !== 1'b1) begin errors++; $display("FAIL reset_dut_reset got=%b want=1", dut_reset); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done); end
    checks++; if (result !== 2'd0 || run_idx !== 2'd0) begin errors++; $display("FAIL reset_result_idx got=%0d/%0d want=0/0", result, run_idx); end
    checks++; if (cycle_count !== 6'd0 || wr_count !== 16'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d want=0/0", cycle_count, wr_count); end
    checks++; if (last_wr_addr !== 32'd0 || last_wr_data !== 32'd0) begin errors++; $display("FAIL reset_wrlog got=%0h/%0h want=0/0", last_wr_addr, last_wr_data); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || dut_reset !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL idle_hold got busy=%b rst=%b done=%b want 0 1 0", busy, dut_reset, done); end
  endtask

  // One full start-to-DONE sequence. s = RUN edge of the signature write (0 = none),
  // d = signature data, nw = filler writes per run, poke = pulse start while busy.
  task automatic run_seq(input string name, input int s, input logic [31:0] d, input int nw, input bit poke);
    exp_t e;
    int rc, rlen, runs;
    bit in_run, got_done;
    if (s == 0 || s > TO) begin
      e.res = 2'd3; e.ridx = 2'd0; e.cyc = TO; e.wrc = 16'(nw); e.runs = 1;
      e.la = (nw > 0) ? 32'h10 + 32'(nw - 1) : 32'd0; e.ld = (nw > 0) ? 32'hAA : 32'd0;
    end else if (d == 32'd7) begin
      e.res = 2'd1; e.ridx = 2'(NR - 1); e.cyc = s; e.wrc = 16'(nw + 1); e.runs = NR;
      e.la = 32'd100; e.ld = 32'd7;
    end else begin
      e.res = 2'd2; e.ridx = 2'd0; e.cyc = s; e.wrc = 16'(nw + 1); e.runs = 1;
      e.la = 32'd100; e.ld = d;
    end
`ifndef SIM_RUN_CTRL_WRLOG_EN
    e.la = 32'd0; e.ld = 32'd0;
`endif
    sb.push_back(e);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (result !== 2'd0 || run_idx !== 2'd0 || wr_count !== 16'd0 || cycle_count !== 6'd0 || busy !== 1'b1)
      begin errors++; $display("FAIL %s_start got res=%0d idx=%0d wr=%0d cyc=%0d busy=%b want 0 0 0 0 1", name, result, run_idx, wr_count, cycle_count, busy); end

    rc = 0; rlen = 0; runs = 0; in_run = 1'b0; got_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin got_done = 1'b1; break; end
      if (dut_reset) begin
        if (in_run) begin in_run = 1'b0; rlen = 0; end
        rlen++;
      end else begin
        if (!in_run) begin
          checks++; if (rlen != RST) begin errors++; $display("FAIL %s_rst_len got=%0d want=%0d", name, rlen, RST); end
          runs++; in_run = 1'b1; rc = 0;
        end else rc++;
        checks++; if (cycle_count !== 6'(rc)) begin errors++; $display("FAIL %s_cycle_count got=%0d want=%0d", name, cycle_count, rc); end
      end
      mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
      if (in_run && s > 0 && rc == s - 1) begin
        mem_we = 1'b1; mem_addr = 32'd100; mem_wdata = d;
      end else if (in_run && rc < nw) begin
        mem_we = 1'b1; mem_addr = 32'h10 + 32'(rc); mem_wdata = 32'hAA;
      end
      start = poke && in_run && rc == 3;
      @(posedge clk); #1;
    end
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; start = 1'b0;

    if (!got_done) begin
      errors++; checks++;
      $display("FAIL %s_done_timeout got done=%b want=1 within 400 cycles", name, done);
    end else if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s_scoreboard got empty queue want one entry", name);
    end else begin
      e = sb.pop_front();
      checks++; if (result !== e.res) begin errors++; $display("FAIL %s_result got=%0d want=%0d", name, result, e.res); end
      checks++; if (run_idx !== e.ridx) begin errors++; $display("FAIL %s_run_idx got=%0d want=%0d", name, run_idx, e.ridx); end
      checks++; if (cycle_count !== 6'(e.cyc) || rc + 1 != e.cyc) begin errors++; $display("FAIL %s_end_cycle got=%0d/%0d want=%0d", name, cycle_count, rc + 1, e.cyc); end
      checks++; if (wr_count !== e.wrc) begin errors++; $display("FAIL %s_wr_count got=%0d want=%0d", name, wr_count, e.wrc); end
      checks++; if (runs != e.runs) begin errors++; $display("FAIL %s_runs got=%0d want=%0d", name, runs, e.runs); end
      checks++; if (last_wr_addr !== e.la || last_wr_data !== e.ld) begin errors++; $display("FAIL %s_wrlog got=%0h/%0h want=%0h/%0h", name, last_wr_addr, last_wr_data, e.la, e.ld); end
      checks++; if (busy !== 1'b0 || dut_reset !== 1'b1) begin errors++; $display("FAIL %s_done_ctrl got busy=%b rst=%b want 0 1", name, busy, dut_reset); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (done !== 1'b1 || result !== e.res || run_idx !== e.ridx || wr_count !== e.wrc)
        begin errors++; $display("FAIL %s_hold got done=%b res=%0d idx=%0d wr=%0d want 1 %0d %0d %0d", name, done, result, run_idx, wr_count, e.res, e.ridx, e.wrc); end
    end
  endtask

  task automatic test_pass_runs();      run_seq("pass",      10, 32'd7, 3, 1'b0); endtask
  task automatic test_fail();           run_seq("fail",      10, 32'd5, 2, 1'b0); endtask
  task automatic test_timeout();        run_seq("timeout",    0, 32'd0, 4, 1'b1); endtask
  task automatic test_sig_at_timeout(); run_seq("sig_at_to", TO, 32'd7, 0, 1'b0); endtask
  task automatic test_wrlog();          run_seq("wrlog",      2, 32'd7, 1, 1'b0); endtask

  task automatic test_async_reset();
    int rc;
    bit reached;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rc = 0; reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!dut_reset) begin
        if (rc == 20) begin reached = 1'b1; break; end
        rc++;
        mem_we = (rc == 5); mem_addr = 32'h20; mem_wdata = 32'h1;
      end
      @(posedge clk); #1;
    end
    mem_we = 1'b0;
    checks++; if (!reached || cycle_count !== 6'd20) begin errors++; $display("FAIL arst_reach got reached=%b cyc=%0d want 1 20", reached, cycle_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dut_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_ctrl got rst=%b busy=%b done=%b want 1 0 0", dut_reset, busy, done); end
    checks++; if (cycle_count !== 6'd0 || wr_count !== 16'd0 || run_idx !== 2'd0 || result !== 2'd0)
      begin errors++; $display("FAIL arst_counts got cyc=%0d wr=%0d idx=%0d res=%0d want 0 0 0 0", cycle_count, wr_count, run_idx, result); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_idle got busy=%b done=%b want 0 0", busy, done); end
    run_seq("after_arst", 10, 32'd7, 3, 1'b0);
  endtask

  initial begin
    test_reset();
    test_pass_runs();
    test_fail();
    test_timeout();
    test_sig_at_timeout();
    test_async_reset();
    test_wrlog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
